// File: rtl/bcd_seven_seg_scan.sv
// Three-digit multiplexed seven-segment driver fed by a binary-to-BCD converter.
// Captured values are shown only from the next frame start, so a frame never mixes two values.
module bcd_seven_seg_scan #(
  parameter int REFRESH_DIV = 4,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [11:0] bcd_in,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic        err,
  output logic        pending,
  output logic        frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  localparam logic [2:0] ST_DIG0 = 3'd0;
  localparam logic [2:0] ST_GAP0 = 3'd1;
  localparam logic [2:0] ST_DIG1 = 3'd2;
  localparam logic [2:0] ST_GAP1 = 3'd3;
  localparam logic [2:0] ST_DIG2 = 3'd4;
  localparam logic [2:0] ST_GAP2 = 3'd5;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [11:0]      r_disp;
  logic [11:0]      r_pend;
  logic             r_pending;
  logic [6:0]       r_seg;
  logic [2:0]       r_an;
  logic             r_err;
  logic             r_fd;

  logic        w_adv;
  logic        w_xfer;
  logic [2:0]  w_state_nxt;
  logic [11:0] w_disp_nxt;
  logic [3:0]  w_digit;
  logic        w_blank;
  logic [6:0]  w_seg;
  logic [2:0]  w_an;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'h3F;
      4'd1:    f_seg = 7'h06;
      4'd2:    f_seg = 7'h5B;
      4'd3:    f_seg = 7'h4F;
      4'd4:    f_seg = 7'h66;
      4'd5:    f_seg = 7'h6D;
      4'd6:    f_seg = 7'h7D;
      4'd7:    f_seg = 7'h07;
      4'd8:    f_seg = 7'h7F;
      4'd9:    f_seg = 7'h6F;
      default: f_seg = 7'h40;
    endcase
  endfunction

  function automatic logic f_bad(input logic [11:0] w);
    f_bad = (w[11:8] > 4'd9) || (w[7:4] > 4'd9) || (w[3:0] > 4'd9);
  endfunction

  // Next state, and the value shown from the state being entered
  always_comb begin
    w_adv       = r_state[0] || (r_cnt == CNT_LAST);
    w_state_nxt = r_state;
    if (w_adv) w_state_nxt = (r_state == ST_GAP2) ? ST_DIG0 : r_state + 3'd1;
    w_xfer     = w_adv && (r_state == ST_GAP2) && r_pending;
    w_disp_nxt = w_xfer ? r_pend : r_disp;

    w_digit = w_disp_nxt[3:0];
    w_blank = 1'b0;
    w_an    = 3'b000;
    case (w_state_nxt)
      ST_DIG0: w_an = 3'b001;
      ST_DIG1: begin
        w_an    = 3'b010;
        w_digit = w_disp_nxt[7:4];
        w_blank = BLANK_LZ && (w_disp_nxt[11:8] == 4'd0) && (w_disp_nxt[7:4] == 4'd0);
      end
      ST_DIG2: begin
        w_an    = 3'b100;
        w_digit = w_disp_nxt[11:8];
        w_blank = BLANK_LZ && (w_disp_nxt[11:8] == 4'd0);
      end
      default: w_an = 3'b000;
    endcase
    w_seg = (w_an == 3'b000 || w_blank) ? 7'h00 : f_seg(w_digit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_GAP2;
      r_cnt     <= '0;
      r_disp    <= '0;
      r_pend    <= '0;
      r_pending <= 1'b0;
      r_seg     <= '0;
      r_an      <= '0;
      r_err     <= 1'b0;
      r_fd      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_adv ? '0 : r_cnt + CNT_W'(1);
      // A load on the transfer edge keeps pending set for the next frame
      r_pending <= load || (r_pending && !w_xfer);
      if (load) r_pend <= bcd_in;
      if (w_xfer) begin
        r_disp <= r_pend;
        r_err  <= f_bad(r_pend);
      end
      r_seg <= w_seg;
      r_an  <= w_an;
      r_fd  <= (w_state_nxt == ST_GAP2);
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign err        = r_err;
  assign pending    = r_pending;
  assign frame_done = r_fd;

endmodule
